// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, hold/flush/perf out.
// The pipeline drives through master; the controller takes slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_mem_r_ena;
  logic [4:0]       ex_reg_w_addr;
  logic             ex_jump;
  logic             mem_req;
  logic             mem_ready;
  logic             hold_pc;
  logic             hold_if_id;
  logic             hold_id_ex;
  logic             hold_ex_mem;
  logic             hold_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1_addr, id_rs2_addr,
    output id_rs1_used, id_rs2_used,
    output ex_mem_r_ena, ex_reg_w_addr,
    output ex_jump, mem_req, mem_ready,
    input  hold_pc, hold_if_id, hold_id_ex,
    input  hold_ex_mem, hold_mem_wb,
    input  flush_if_id, flush_id_ex,
    input  mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr,
    input  id_rs1_used, id_rs2_used,
    input  ex_mem_r_ena, ex_reg_w_addr,
    input  ex_jump, mem_req, mem_ready,
    output hold_pc, hold_if_id, hold_id_ex,
    output hold_ex_mem, hold_mem_wb,
    output flush_if_id, flush_id_ex,
    output mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use, EX jumps, slow data memory
// with a timeout watchdog, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic              clk_100MHz,
  input logic              arst_n,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_t;

  localparam logic [7:0] TMO_LAST =
    8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_wait;
  logic             r_tmo;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  logic w_mem_stall;
  logic w_lu;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hold_all;
  logic w_hpc;
  logic w_hifid;
  logic w_hidex;
  logic w_hexmem;
  logic w_hmemwb;
  logic w_fifid;
  logic w_fidex;

  assign w_mem_stall = hz.mem_req & ~hz.mem_ready;

  assign w_rs1_hit = hz.id_rs1_used &
    (hz.id_rs1_addr == hz.ex_reg_w_addr);
  assign w_rs2_hit = hz.id_rs2_used &
    (hz.id_rs2_addr == hz.ex_reg_w_addr);
  assign w_lu = hz.ex_mem_r_ena &
    (hz.ex_reg_w_addr != 5'd0) &
    (w_rs1_hit | w_rs2_hit);

  always_comb begin
    w_hold_all = 1'b1;
    unique case (r_state)
      RUN:      w_hold_all = w_mem_stall;
      MEM_WAIT: w_hold_all = ~hz.mem_ready;
      ERR:      w_hold_all = 1'b1;
      default:  w_hold_all = 1'b1;
    endcase
  end

  // jump and load-use can coincide, so this is a priority decode
  always_comb begin
    w_hpc    = 1'b0;
    w_hifid  = 1'b0;
    w_hidex  = 1'b0;
    w_hexmem = 1'b0;
    w_hmemwb = 1'b0;
    w_fifid  = 1'b0;
    w_fidex  = 1'b0;
    if (arst_n) begin
      priority case (1'b1)
        w_hold_all: begin
          w_hpc    = 1'b1;
          w_hifid  = 1'b1;
          w_hidex  = 1'b1;
          w_hexmem = 1'b1;
          w_hmemwb = 1'b1;
        end
        hz.ex_jump: begin
          w_fifid = 1'b1;
          w_fidex = 1'b1;
        end
        w_lu: begin
          w_hpc   = 1'b1;
          w_hifid = 1'b1;
          w_fidex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= RUN;
      r_wait  <= 8'd0;
      r_tmo   <= 1'b0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (w_hpc && r_stall != '1)
        r_stall <= r_stall + CNT_ONE;
      if (w_fifid && r_flush != '1)
        r_flush <= r_flush + CNT_ONE;
      unique case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state <= MEM_WAIT;
            r_wait  <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            r_state <= RUN;
          end else if (r_wait == TMO_LAST) begin
            r_state <= ERR;
            r_tmo   <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= ERR;
      endcase
    end
  end

  assign hz.hold_pc      = w_hpc;
  assign hz.hold_if_id   = w_hifid;
  assign hz.hold_id_ex   = w_hidex;
  assign hz.hold_ex_mem  = w_hexmem;
  assign hz.hold_mem_wb  = w_hmemwb;
  assign hz.flush_if_id  = w_fifid;
  assign hz.flush_id_ex  = w_fidex;
  assign hz.mem_timeout  = r_tmo;
  assign hz.stall_cycles = r_stall;
  assign hz.flush_count  = r_flush;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow-counter twin
// shares the stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;
  logic clk_100MHz = 1'b0;
  logic arst_n     = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  pipe_hazard_ctrl_if #(.CNT_W(32)) m_if ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  s_if ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) u_dut (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .hz         (m_if.slave)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) u_sat (
    .clk_100MHz (clk_100MHz),
    .arst_n     (arst_n),
    .hz         (s_if.slave)
  );

  assign s_if.id_rs1_addr   = m_if.id_rs1_addr;
  assign s_if.id_rs2_addr   = m_if.id_rs2_addr;
  assign s_if.id_rs1_used   = m_if.id_rs1_used;
  assign s_if.id_rs2_used   = m_if.id_rs2_used;
  assign s_if.ex_mem_r_ena  = m_if.ex_mem_r_ena;
  assign s_if.ex_reg_w_addr = m_if.ex_reg_w_addr;
  assign s_if.ex_jump       = m_if.ex_jump;
  assign s_if.mem_req       = m_if.mem_req;
  assign s_if.mem_ready     = m_if.mem_ready;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_ALL  = 7'b1111100;
  localparam logic [6:0] C_JMP  = 7'b0000011;
  localparam logic [6:0] C_LU   = 7'b1100001;

  function automatic logic [6:0] ctl_obs();
    return {m_if.hold_pc, m_if.hold_if_id,
            m_if.hold_id_ex, m_if.hold_ex_mem,
            m_if.hold_mem_wb, m_if.flush_if_id,
            m_if.flush_id_ex};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs1,
                     input logic [4:0] rs2,
                     input logic u1, input logic u2,
                     input logic ld,
                     input logic [4:0] rd,
                     input logic jmp, input logic req,
                     input logic rdy);
    m_if.id_rs1_addr   = rs1;
    m_if.id_rs2_addr   = rs2;
    m_if.id_rs1_used   = u1;
    m_if.id_rs2_used   = u2;
    m_if.ex_mem_r_ena  = ld;
    m_if.ex_reg_w_addr = rd;
    m_if.ex_jump       = jmp;
    m_if.mem_req       = req;
    m_if.mem_ready     = rdy;
  endtask

  task automatic cyc(input string tag,
                     input logic [6:0] ctl);
    exp_t e;
    exp_t g;
    e.tag = tag;
    e.ctl = ctl;
    sb.push_back(e);
    @(negedge clk_100MHz);
    g = sb.pop_front();
    chk(g.tag, 32'(ctl_obs()), 32'(g.ctl));
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    drv(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5,
        1'b1, 1'b1, 1'b0);
    #2;
    cyc("in_reset", C_NONE);
    chk("rst_stall", m_if.stall_cycles, 32'd0);
    chk("rst_flush", m_if.flush_count, 32'd0);
    chk("rst_tmo", 32'(m_if.mem_timeout), 32'd0);
    arst_n = 1'b1;
    idle();
    cyc("idle", C_NONE);

    drv(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5,
        1'b0, 1'b0, 1'b0);
    cyc("lu_rs2", C_LU);
    drv(5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0,
        1'b0, 1'b0, 1'b0);
    cyc("lu_bubble", C_NONE);
    chk("lu_stall_cnt", m_if.stall_cycles, 32'd1);
    drv(5'd7, 5'd2, 1'b0, 1'b1, 1'b1, 5'd7,
        1'b0, 1'b0, 1'b0);
    cyc("lu_rs1_unused", C_NONE);
    drv(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0,
        1'b0, 1'b0, 1'b0);
    cyc("lu_x0", C_NONE);
    chk("lu_x0_cnt", m_if.stall_cycles, 32'd1);

    idle();
    m_if.ex_jump = 1'b1;
    cyc("jump", C_JMP);
    idle();
    cyc("jump_after", C_NONE);
    chk("jump_cnt", m_if.flush_count, 32'd1);
    drv(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3,
        1'b1, 1'b0, 1'b0);
    cyc("jump_over_lu", C_JMP);
    chk("jump_lu_cnt", m_if.flush_count, 32'd2);

    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("mem3_wait", C_ALL);
    chk("mem3_no_tmo", 32'(m_if.mem_timeout), 32'd0);
    m_if.mem_ready = 1'b1;
    cyc("mem3_done", C_NONE);
    chk("mem3_cnt", m_if.stall_cycles, 32'd4);
    cyc("zero_wait", C_NONE);
    chk("zero_wait_cnt", m_if.stall_cycles, 32'd4);

    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("jmp_in_stall", C_ALL);
    m_if.mem_ready = 1'b1;
    cyc("jmp_release", C_JMP);
    chk("jmp_stall_fc", m_if.flush_count, 32'd3);
    chk("jmp_stall_sc", m_if.stall_cycles, 32'd6);

    drv(5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9,
        1'b0, 1'b1, 1'b0);
    cyc("lu_vs_mem", C_ALL);
    m_if.mem_ready = 1'b1;
    cyc("lu_release", C_LU);
    idle();
    cyc("lu_rel_after", C_NONE);
    chk("lu_mem_sc", m_if.stall_cycles, 32'd8);
    chk("lu_mem_fc", m_if.flush_count, 32'd3);

    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("tmo_wait", C_ALL);
    chk("tmo_not_yet", 32'(m_if.mem_timeout), 32'd0);
    cyc("tmo_last", C_ALL);
    chk("tmo_set", 32'(m_if.mem_timeout), 32'd1);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cyc("err_stuck", C_ALL);
    chk("err_tmo", 32'(m_if.mem_timeout), 32'd1);
    chk("err_sc", m_if.stall_cycles, 32'd14);
    chk("sat_sc", 32'(s_if.stall_cycles), 32'd7);
    chk("sat_fc_pre", 32'(s_if.flush_count), 32'd3);

    arst_n = 1'b0;
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
        1'b0, 1'b1, 1'b0);
    #1;
    chk("arst_sc", m_if.stall_cycles, 32'd0);
    chk("arst_fc", m_if.flush_count, 32'd0);
    chk("arst_tmo", 32'(m_if.mem_timeout), 32'd0);
    cyc("arst_out", C_NONE);
    arst_n = 1'b1;
    m_if.mem_ready = 1'b1;
    cyc("post_rst_run", C_NONE);
    chk("post_rst_sc", m_if.stall_cycles, 32'd0);

    idle();
    m_if.ex_jump = 1'b1;
    for (int i = 0; i < 9; i++) cyc("jump_burst", C_JMP);
    chk("burst_fc", m_if.flush_count, 32'd9);
    chk("sat_fc", 32'(s_if.flush_count), 32'd7);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end
endmodule
